// File: rtl/graphic_arb_pkg.sv
// Shared encodings for the chart RAM arbiter: owner tags, arbitration states, default host wait limit.
// No logic, no latency, no flow control.
// Owner tags travel down the read pipeline; OWN_NONE marks idle or write slots.
package graphic_arb_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t OWN_NONE   = 2'd0;
    localparam owner_t OWN_RENDER = 2'd1;
    localparam owner_t OWN_HOST   = 2'd2;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FORCE  = 2'd1,
        ST_BLANK  = 2'd2
    } arb_state_t;

    localparam int MAX_WAIT_DEF = 15;

endpackage

// File: rtl/arb_starve_timer.sv
// Counts consecutive denied host cycles, saturating at MAX_WAIT; hit flags the limit.
// Latency: count updates one cycle after inc/clr, hit is combinational from the count.
// Backpressure: none; clr has priority over inc.
module arb_starve_timer
    import graphic_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic hit
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != LIMIT)) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign hit = (cnt == LIMIT);

endmodule

// File: rtl/chart_mem_arbiter.sv
// Arbitrates the renderer and host ports onto one single-port chart RAM; optional stats via CHART_ARB_STATS_EN.
// Latency: grant combinational, RAM command at T+1, read data/rvalid at T+2; one access per cycle.
// Backpressure: losing requester holds its request until granted; renderer loses only on forced host slots or blank-time round-robin.
module chart_mem_arbiter
    import graphic_arb_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 16,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          vblank,
    input  logic          r_req,
    input  logic [AW-1:0] r_addr,
    output logic          r_gnt,
    output logic          r_rvalid,
    output logic [DW-1:0] r_rdata,
    output logic          r_miss,
    input  logic          h_req,
    input  logic          h_we,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] h_wdata,
    output logic          h_gnt,
    output logic          h_rvalid,
    output logic [DW-1:0] h_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef CHART_ARB_STATS_EN
    ,
    input  logic          stats_clr,
    output logic [15:0]   miss_cnt,
    output logic [15:0]   force_cnt
`endif
);

    arb_state_t state_q, state_d;
    owner_t     last_owner, tag1, tag2;
    logic       starve_hit, force_entry;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // The mode is chosen from this cycle's vblank and starvation status so edges act immediately.
    always_comb begin
        state_d = ST_ACTIVE;
        r_gnt   = 1'b0;
        h_gnt   = 1'b0;
        if (vblank) begin
            state_d = ST_BLANK;
        end else if (starve_hit && h_req) begin
            state_d = ST_FORCE;
        end
        case (state_d)
            ST_FORCE: h_gnt = 1'b1;
            ST_BLANK: begin
                if (r_req && h_req) begin
                    r_gnt = (last_owner != OWN_RENDER);
                    h_gnt = (last_owner == OWN_RENDER);
                end else begin
                    r_gnt = r_req;
                    h_gnt = h_req;
                end
            end
            default: begin
                r_gnt = r_req;
                h_gnt = h_req && !r_req;
            end
        endcase
    end

    assign force_entry = (state_d == ST_FORCE) && (state_q != ST_FORCE);

    arb_starve_timer #(.MAX_WAIT(MAX_WAIT)) u_starve (
        .clk (hclk),
        .rst (hreset),
        .inc ((state_d == ST_ACTIVE) && h_req && !h_gnt),
        .clr (h_gnt || !h_req),
        .hit (starve_hit)
    );

    always_ff @(posedge hclk) begin
        if (hreset) begin
            last_owner <= OWN_HOST;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            r_miss     <= 1'b0;
            tag1       <= OWN_NONE;
            tag2       <= OWN_NONE;
        end else begin
            mem_en <= r_gnt || h_gnt;
            mem_we <= h_gnt && h_we;
            r_miss <= force_entry && r_req;
            tag2   <= tag1;
            if (r_gnt) begin
                last_owner <= OWN_RENDER;
                mem_addr   <= r_addr;
                tag1       <= OWN_RENDER;
            end else if (h_gnt) begin
                last_owner <= OWN_HOST;
                mem_addr   <= h_addr;
                mem_wdata  <= h_wdata;
                tag1       <= h_we ? OWN_NONE : OWN_HOST;
            end else begin
                tag1 <= OWN_NONE;
            end
        end
    end

    assign r_rvalid = (tag2 == OWN_RENDER);
    assign h_rvalid = (tag2 == OWN_HOST);
    assign r_rdata  = r_rvalid ? mem_rdata : '0;
    assign h_rdata  = h_rvalid ? mem_rdata : '0;

`ifdef CHART_ARB_STATS_EN
    always_ff @(posedge hclk) begin
        if (hreset || stats_clr) begin
            miss_cnt  <= '0;
            force_cnt <= '0;
        end else begin
            if (force_entry && r_req && (miss_cnt != 16'hFFFF)) begin
                miss_cnt <= miss_cnt + 16'd1;
            end
            if (force_entry && (force_cnt != 16'hFFFF)) begin
                force_cnt <= force_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_chart_mem_arbiter.sv
// Randomized bench for chart_mem_arbiter with a cycle-level reference model and read-data scoreboard.
module tb_chart_mem_arbiter;
    import graphic_arb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MW = 15;

    logic          hclk = 1'b0;
    logic          hreset, vblank, r_req, h_req, h_we, stats_clr;
    logic [AW-1:0] r_addr, h_addr;
    logic [DW-1:0] h_wdata;
    logic          r_gnt, r_rvalid, r_miss, h_gnt, h_rvalid;
    logic [DW-1:0] r_rdata, h_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [15:0]   miss_cnt, force_cnt;

    chart_mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
        .hclk(hclk), .hreset(hreset), .vblank(vblank),
        .r_req(r_req), .r_addr(r_addr), .r_gnt(r_gnt), .r_rvalid(r_rvalid),
        .r_rdata(r_rdata), .r_miss(r_miss),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef CHART_ARB_STATS_EN
        , .stats_clr(stats_clr), .miss_cnt(miss_cnt), .force_cnt(force_cnt)
`endif
    );

`ifndef CHART_ARB_STATS_EN
    assign miss_cnt  = '0;
    assign force_cnt = '0;
`endif

    always #5 hclk = ~hclk;

    // Chart RAM fixture: synchronous single port, read data one cycle after enable.
    logic [DW-1:0] ram [0:4095];
    always @(posedge hclk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model state
    logic [DW-1:0] m_mem [0:4095];
    logic [DW-1:0] rq[$], hq[$];
    int            m_streak, m_fc, m_mc;
    bit            m_last_r, m_gr, m_gh;
    logic          e_en, e_we, e_miss;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    bit            seen_h, seen_r, seen_rv, mon_en;
    int            r_rv_cnt, h_rv_cnt;

    // Monitor: pops expected read data whenever the DUT presents a response.
    initial begin
        mon_en = 0; r_rv_cnt = 0; h_rv_cnt = 0;
        forever begin
            @(negedge hclk);
            if (mon_en) begin
                if (r_rvalid) begin
                    r_rv_cnt++;
                    if (rq.size() == 0) check("r_rvalid_unexpected", 1, 0);
                    else check("r_rdata", r_rdata, rq.pop_front());
                end else check("r_rdata_idle", r_rdata, 0);
                if (h_rvalid) begin
                    h_rv_cnt++;
                    if (hq.size() == 0) check("h_rvalid_unexpected", 1, 0);
                    else check("h_rdata", h_rdata, hq.pop_front());
                end else check("h_rdata_idle", h_rdata, 0);
            end
        end
    end

    // One clock cycle: compare DUT against the model, then advance the model.
    task automatic step();
        bit forced;
        @(negedge hclk); #1;
        seen_r = r_gnt; seen_h = h_gnt; seen_rv = r_rvalid;
        if (hreset) begin
            m_streak = 0; m_last_r = 0; m_fc = 0; m_mc = 0; m_gr = 0; m_gh = 0;
            rq.delete(); hq.delete();
            e_en = 0; e_we = 0; e_miss = 0; e_addr = '0; e_wdata = '0;
        end else begin
            check("mem_en", mem_en, e_en);
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_wdata", mem_wdata, e_wdata);
            check("r_miss", r_miss, e_miss);
`ifdef CHART_ARB_STATS_EN
            check("force_cnt", force_cnt, m_fc);
            check("miss_cnt", miss_cnt, m_mc);
`endif
            forced = 0;
            if (vblank) begin
                if (r_req && h_req) begin m_gr = !m_last_r; m_gh = m_last_r; end
                else begin m_gr = r_req; m_gh = h_req; end
            end else if (h_req && m_streak >= MW) begin
                m_gr = 0; m_gh = 1; forced = 1;
            end else begin
                m_gr = r_req; m_gh = h_req && !r_req;
            end
            check("r_gnt", r_gnt, m_gr);
            check("h_gnt", h_gnt, m_gh);

            if (m_gh || !h_req) m_streak = 0;
            else if (!vblank && m_streak < MW) m_streak++;
            if (m_gr) m_last_r = 1;
            else if (m_gh) m_last_r = 0;

            e_en = m_gr || m_gh; e_we = m_gh && h_we; e_miss = forced && r_req;
            if (m_gr) begin
                e_addr = r_addr; rq.push_back(m_mem[r_addr]);
            end else if (m_gh) begin
                e_addr = h_addr; e_wdata = h_wdata;
                if (h_we) m_mem[h_addr] = h_wdata;
                else hq.push_back(m_mem[h_addr]);
            end
            if (stats_clr) begin m_fc = 0; m_mc = 0; end
            else begin
                if (forced && m_fc < 65535) m_fc++;
                if (forced && r_req && m_mc < 65535) m_mc++;
            end
        end
        @(posedge hclk); #1;
    endtask

    task automatic idle(input int n);
        r_req = 0; h_req = 0; vblank = 0; stats_clr = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int first, base, nforce;
        logic [5:0] pat;
        hreset = 1; vblank = 0; r_req = 0; h_req = 0; h_we = 0; stats_clr = 0;
        r_addr = '0; h_addr = '0; h_wdata = '0;
        for (int i = 0; i < 4096; i++) begin
            ram[i] = DW'(i + 'h100); m_mem[i] = DW'(i + 'h100);
        end
        @(posedge hclk); #1;
        step(); step();
        hreset = 0; mon_en = 1;
        idle(1);

        // Host write then read of 0x010
        h_req = 1; h_we = 1; h_addr = 12'h010; h_wdata = 16'hBEEF; step();
        h_we = 0; step();
        base = h_rv_cnt; idle(3);
        check("host_read_count", h_rv_cnt - base, 1);

        // Starvation: renderer hogs during active video
        r_req = 1; r_addr = 12'h005; h_req = 1; h_we = 0; h_addr = 12'h010; first = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (seen_h && first == 0) begin first = i; h_req = 0; end
        end
        check("starve_first_hgnt", first, 16);
        idle(3);

        // Blanking round-robin from reset
        hreset = 1; step(); hreset = 0;
        vblank = 1; r_req = 1; h_req = 1; h_we = 0; r_addr = 12'h002; h_addr = 12'h003; pat = '0;
        for (int i = 0; i < 6; i++) begin step(); pat = {pat[4:0], seen_r}; end
        check("blank_rr_pattern", pat, 6'b101010);
        idle(3);

        // Renderer burst 0..7
        base = r_rv_cnt;
        for (int i = 0; i < 8; i++) begin r_req = 1; r_addr = AW'(i); step(); end
        idle(4);
        check("burst_rvalid_count", r_rv_cnt - base, 8);

        // Reset one cycle after a renderer read grant drops the read
        r_req = 1; r_addr = 12'h004; step();
        r_req = 0; hreset = 1; step(); hreset = 0;
        step();
        check("reset_drops_rvalid", seen_rv, 0);
        idle(2);

`ifdef CHART_ARB_STATS_EN
        r_req = 1; r_addr = 12'h001; h_req = 1; h_we = 0; h_addr = 12'h002; nforce = 0;
        for (int i = 0; i < 80 && nforce < 4; i++) begin
            if (m_streak == MW) begin
                nforce++;
                if (nforce == 4) begin
                    check("force_cnt_before_clr", force_cnt, 3);
                    stats_clr = 1; step(); stats_clr = 0;
                    check("force_cnt_after_clr", force_cnt, 0);
                end else step();
            end else step();
        end
        check("force_slots_seen", nforce, 4);
        idle(3);
`endif

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) vblank = ~vblank;
            if (!r_req || m_gr) begin
                r_req = ($urandom_range(0, 9) < 7); r_addr = AW'($urandom_range(0, 31));
            end
            if (!h_req || m_gh) begin
                h_req = ($urandom_range(0, 9) < 4); h_we = 1'($urandom_range(0, 1));
                h_addr = AW'($urandom_range(0, 31)); h_wdata = DW'($urandom);
            end
            step();
        end
        idle(4);
        check("r_queue_drained", rq.size(), 0);
        check("h_queue_drained", hq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
